// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: scans a 4x4 PmodKYPD, debounces one key and emits its hex code with a one-cycle strobe.
// Latency: up to 2 (row sync) + one scan period + debounce count cycles from a stable press to key_valid.
// No backpressure: key_valid is a single-cycle pulse and key_code holds until the next one. Macro KEYPAD_REPEAT_EN adds auto-repeat.
module keypad_scan_debounce #(
   parameter int unsigned CLK_FREQ    = 100_000_000,
   parameter int unsigned SCAN_US     = 1000,
   parameter int unsigned DEBOUNCE_MS = 10,
   parameter int unsigned REPEAT_MS   = 250
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row,
   output logic [3:0] col,
   output logic [3:0] key_code,
   output logic       key_valid,
   output logic       key_held
);

   // Cycle counts are formed in 64 bits because ms * Hz overflows 32 bits.
   localparam logic [63:0] SCAN_CYC  = 64'(SCAN_US) * 64'(CLK_FREQ) / 64'd1_000_000;
   localparam logic [31:0] SCAN_LAST = 32'(SCAN_CYC - 64'd1);
   localparam logic [63:0] DEB_CYC   = 64'(DEBOUNCE_MS) * 64'(CLK_FREQ) / 64'd1000;
   localparam logic [31:0] DEB_LAST  = 32'(DEB_CYC - 64'd1);

   // Key legend indexed by {column index, row index}; index 0 is the MSB-low line.
   localparam logic [3:0] KEYMAP [16] = '{4'h1, 4'h4, 4'h7, 4'h0,
                                          4'h2, 4'h5, 4'h8, 4'hF,
                                          4'h3, 4'h6, 4'h9, 4'hE,
                                          4'hA, 4'hB, 4'hC, 4'hD};

   typedef enum logic [1:0] {SCAN, DEB_PRESS, HELD, DEB_REL} state_t;

   state_t      st, st_nxt;
   logic [31:0] cnt, cnt_nxt;
   logic [3:0]  row_meta, row_sync;
   logic [3:0]  smp, smp_nxt;
   logic [3:0]  col_nxt, code_nxt;
   logic        vld_nxt, held_nxt;

`ifdef KEYPAD_REPEAT_EN
   localparam logic [63:0] REP_CYC  = 64'(REPEAT_MS) * 64'(CLK_FREQ) / 64'd1000;
   localparam logic [31:0] REP_LAST = 32'(REP_CYC - 64'd1);
   logic [31:0] rcnt, rcnt_nxt;
`else
   // REPEAT_MS has no effect in this build; no repeat hardware exists.
   if (REPEAT_MS == 0) begin : g_repeat_ignored
   end
`endif

   // Line index of the single low bit (0 = bit 3 low).
   function automatic logic [1:0] idx_of(input logic [3:0] v);
      case (v)
         4'b1011: return 2'd1;
         4'b1101: return 2'd2;
         4'b1110: return 2'd3;
         default: return 2'd0;
      endcase
   endfunction

   // True when exactly one row is low, i.e. the press is unambiguous.
   function automatic logic one_low(input logic [3:0] v);
      return (v == 4'b0111) || (v == 4'b1011) || (v == 4'b1101) || (v == 4'b1110);
   endfunction

   // All flops, including the row synchroniser, share one asynchronous reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_meta  <= 4'hF;
         row_sync  <= 4'hF;
         st        <= SCAN;
         cnt       <= '0;
         smp       <= 4'hF;
         col       <= 4'b0111;
         key_code  <= 4'h0;
         key_valid <= 1'b0;
         key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
         rcnt      <= '0;
`endif
      end else begin
         row_meta  <= row;
         row_sync  <= row_meta;
         st        <= st_nxt;
         cnt       <= cnt_nxt;
         smp       <= smp_nxt;
         col       <= col_nxt;
         key_code  <= code_nxt;
         key_valid <= vld_nxt;
         key_held  <= held_nxt;
`ifdef KEYPAD_REPEAT_EN
         rcnt      <= rcnt_nxt;
`endif
      end
   end

   // Scan / debounce sequencing; every state change clears the dwell counter.
   always_comb begin
      st_nxt   = st;
      cnt_nxt  = cnt + 32'd1;
      smp_nxt  = smp;
      col_nxt  = col;
      code_nxt = key_code;
      vld_nxt  = 1'b0;
      held_nxt = key_held;
`ifdef KEYPAD_REPEAT_EN
      rcnt_nxt = rcnt + 32'd1;
`endif
      case (st)
         SCAN: begin
            if (cnt == SCAN_LAST) begin
               cnt_nxt = '0;
               if (row_sync != 4'hF) begin
                  st_nxt  = DEB_PRESS;
                  smp_nxt = row_sync;
               end else begin
                  col_nxt = {col[0], col[3:1]};
               end
            end
         end
         DEB_PRESS: begin
            // Ambiguous, changed or released pattern: give up and move on to the next column.
            if (!one_low(smp) || row_sync != smp) begin
               st_nxt  = SCAN;
               cnt_nxt = '0;
               col_nxt = {col[0], col[3:1]};
            end else if (cnt == DEB_LAST) begin
               st_nxt   = HELD;
               cnt_nxt  = '0;
               code_nxt = KEYMAP[{idx_of(col), idx_of(smp)}];
               vld_nxt  = 1'b1;
               held_nxt = 1'b1;
`ifdef KEYPAD_REPEAT_EN
               rcnt_nxt = '0;
`endif
            end
         end
         HELD: begin
            if (row_sync == 4'hF) begin
               st_nxt  = DEB_REL;
               cnt_nxt = '0;
            end
`ifdef KEYPAD_REPEAT_EN
            else if (rcnt == REP_LAST) begin
               vld_nxt  = 1'b1;
               rcnt_nxt = '0;
            end
`endif
         end
         DEB_REL: begin
            if (row_sync != 4'hF) begin
               st_nxt  = HELD;
               cnt_nxt = '0;
`ifdef KEYPAD_REPEAT_EN
               rcnt_nxt = '0;
`endif
            end else if (cnt == DEB_LAST) begin
               st_nxt   = SCAN;
               cnt_nxt  = '0;
               held_nxt = 1'b0;
               col_nxt  = {col[0], col[3:1]};
            end
         end
      endcase
   end

endmodule

// File: tb/tb_keypad_scan_debounce.sv
// Bench for keypad_scan_debounce: a keypad model drives rows from the scanned column,
// a timing model predicts col/key_code/key_valid/key_held every cycle, and directed
// phases pin press, bounce, release glitch, ambiguity, reset and repeat behaviour.
module tb_keypad_scan_debounce;
   localparam int SCAN = 4;
   localparam int DEB  = 1000;
   localparam int REP  = 2000;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row, col, key_code;
   logic       key_valid, key_held;

   logic [15:0] pressed;
   logic        force_en;
   logic [3:0]  force_val, kp_row;
   logic [3:0]  kmap [16] = '{4'h1, 4'h4, 4'h7, 4'h0, 4'h2, 4'h5, 4'h8, 4'hF,
                              4'h3, 4'h6, 4'h9, 4'hE, 4'hA, 4'hB, 4'hC, 4'hD};

   int n_chk = 0;
   int n_pass = 0;
   int pulses = 0;

   always #5 clk = ~clk;

   keypad_scan_debounce #(
      .CLK_FREQ(1_000_000), .SCAN_US(4), .DEBOUNCE_MS(1), .REPEAT_MS(2)
   ) dut (
      .clk(clk), .rst(rst), .row(row), .col(col),
      .key_code(key_code), .key_valid(key_valid), .key_held(key_held)
   );

   function automatic logic [3:0] col_of(input int c);
      logic [3:0] v;
      v = 4'hF;
      v[3-c] = 1'b0;
      return v;
   endfunction

   // Physical keypad: a pressed key pulls its row low while its column is driven low.
   always_comb begin
      kp_row = 4'hF;
      for (int c = 0; c < 4; c++)
         if (col == col_of(c))
            for (int r = 0; r < 4; r++)
               if (pressed[kmap[c*4+r]]) kp_row[3-r] = 1'b0;
   end
   assign row = force_en ? force_val : kp_row;

   // Reference model: column index, phase and a countdown of remaining cycles.
   localparam int M_SCAN = 0, M_PRESS = 1, M_DOWN = 2, M_REL = 3;
   int         m_mode, m_left, m_ci, m_rep, m_nz, m_ri;
   logic [3:0] m_q1, m_q2, m_r, m_pat, m_code;
   logic       m_vld, m_held;

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         m_mode = M_SCAN; m_left = SCAN; m_ci = 0; m_rep = REP;
         m_q1 = 4'hF; m_q2 = 4'hF; m_pat = 4'hF;
         m_code = 4'h0; m_vld = 1'b0; m_held = 1'b0;
      end else begin
         m_r = m_q2;
         m_q2 = m_q1;
         m_q1 = row;
         m_vld = 1'b0;
         case (m_mode)
            M_SCAN: begin
               m_left = m_left - 1;
               if (m_left == 0) begin
                  if (m_r != 4'hF) begin
                     m_mode = M_PRESS; m_pat = m_r; m_left = DEB;
                  end else begin
                     m_ci = (m_ci + 1) % 4; m_left = SCAN;
                  end
               end
            end
            M_PRESS: begin
               m_nz = 0; m_ri = 0;
               for (int i = 0; i < 4; i++)
                  if (!m_pat[3-i]) begin m_nz++; m_ri = i; end
               if (m_nz != 1 || m_r != m_pat) begin
                  m_mode = M_SCAN; m_ci = (m_ci + 1) % 4; m_left = SCAN;
               end else begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_mode = M_DOWN; m_code = kmap[m_ci*4+m_ri];
                     m_vld = 1'b1; m_held = 1'b1; m_rep = REP;
                  end
               end
            end
            M_DOWN: begin
               if (m_r == 4'hF) begin
                  m_mode = M_REL; m_left = DEB;
               end else begin
`ifdef KEYPAD_REPEAT_EN
                  m_rep = m_rep - 1;
                  if (m_rep == 0) begin m_vld = 1'b1; m_rep = REP; end
`endif
               end
            end
            default: begin
               if (m_r != 4'hF) begin
                  m_mode = M_DOWN; m_rep = REP;
               end else begin
                  m_left = m_left - 1;
                  if (m_left == 0) begin
                     m_mode = M_SCAN; m_held = 1'b0; m_ci = (m_ci + 1) % 4; m_left = SCAN;
                  end
               end
            end
         endcase
      end
   end

   task automatic cmp_cycle();
      n_chk++;
      if ({col, key_code, key_valid, key_held} === {col_of(m_ci), m_code, m_vld, m_held})
         n_pass++;
      else
         $display("FAIL model_cycle t=%0t col=%b/%b code=%h/%h valid=%b/%b held=%b/%b (dut/model)",
                  $time, col, col_of(m_ci), key_code, m_code, key_valid, m_vld, key_held, m_held);
      if (key_valid === 1'b1) pulses++;
   endtask

   // Advance n clock cycles, checking the model at each falling edge; returns 2 units after a rising edge.
   task automatic cyc(input int n);
      repeat (n) begin
         @(negedge clk);
         cmp_cycle();
         @(posedge clk);
         #2;
      end
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   initial begin
      int p0;
      logic [3:0] c_a;
      rst = 1'b0; pressed = '0; force_en = 1'b1; force_val = 4'h0;

      // Reset with all rows low.
      cyc(5);
      chk("reset_col", int'(col), 4'b0111);
      chk("reset_code", int'(key_code), 0);
      chk("reset_valid", int'(key_valid), 0);
      chk("reset_held", int'(key_held), 0);
      rst = 1'b1; force_en = 1'b0;
      cyc(4);  chk("rot_1", int'(col), 4'b1011);
      cyc(4);  chk("rot_2", int'(col), 4'b1101);
      cyc(4);  chk("rot_3", int'(col), 4'b1110);
      cyc(4);  chk("rot_4", int'(col), 4'b0111);

      // Press '5' (column 1011, row 1011).
      p0 = pulses; pressed = 16'h0020;
      cyc(1200);
      chk("press5_pulses", pulses - p0, 1);
      chk("press5_code", int'(key_code), 5);
      chk("press5_held", int'(key_held), 1);
      chk("press5_col", int'(col), 4'b1011);
      pressed = '0;
      cyc(1100);
      chk("press5_release", int'(key_held), 0);

      // Bouncing '1': 300-cycle contacts never survive the debounce window.
      p0 = pulses;
      repeat (3) begin
         pressed = 16'h0002; cyc(300);
         pressed = '0;       cyc(300);
      end
      chk("bounce_pulses", pulses - p0, 0);
      pressed = 16'h0002;
      cyc(1100);
      chk("key1_pulses", pulses - p0, 1);
      chk("key1_code", int'(key_code), 1);

      // Release with a one-cycle blip 500 cycles in.
      p0 = pulses; pressed = '0;
      cyc(500);
      pressed = 16'h0002; cyc(1);
      pressed = '0;       cyc(10);
      chk("glitch_held", int'(key_held), 1);
      cyc(1100);
      chk("glitch_release", int'(key_held), 0);
      chk("glitch_pulses", pulses - p0, 0);
      c_a = col; cyc(4);
      chk("scan_resumed", int'(col != c_a), 1);

      // Ambiguous C+D in column 1110 (row 1100).
      p0 = pulses; pressed = 16'h3000;
      cyc(200);
      chk("ambig_pulses", pulses - p0, 0);
      chk("ambig_code", int'(key_code), 1);
      pressed = '0;
      cyc(20);

      // Asynchronous reset mid-debounce.
      pressed = 16'h0020;
      cyc(500);
      #1 rst = 1'b0;
      pressed = '0;
      cyc(5);
      chk("rst_col", int'(col), 4'b0111);
      chk("rst_code", int'(key_code), 0);
      chk("rst_held", int'(key_held), 0);
      rst = 1'b1;
      cyc(1100);
      chk("rst_pulses", pulses - p0, 0);
      chk("rst_code_after", int'(key_code), 0);

      // Long hold of 'D'.
      p0 = pulses; pressed = 16'h2000;
      cyc(6000);
`ifdef KEYPAD_REPEAT_EN
      chk("hold_d_pulses", pulses - p0, 3);
`else
      chk("hold_d_pulses", pulses - p0, 1);
`endif
      chk("hold_d_code", int'(key_code), 13);
      pressed = '0;
      cyc(1100);
      chk("hold_d_release", int'(key_held), 0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
